// File: rtl/result_display.sv
// Result display stage: captures the evaluator's 8-bit result on each rising edge of valid,
// converts it to three BCD digits by sequential double-dabble and drives LEDR plus HEX2..HEX0.
module result_display #(
    parameter bit INVERT_SEG = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [7:0] ledr,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    // Segment pattern for one digit, g..a order, blanked and polarity-adjusted.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
        logic [6:0] seg_v;
        case (digit)
            4'd0:    seg_v = 7'h3F;
            4'd1:    seg_v = 7'h06;
            4'd2:    seg_v = 7'h5B;
            4'd3:    seg_v = 7'h4F;
            4'd4:    seg_v = 7'h66;
            4'd5:    seg_v = 7'h6D;
            4'd6:    seg_v = 7'h7D;
            4'd7:    seg_v = 7'h07;
            4'd8:    seg_v = 7'h7F;
            4'd9:    seg_v = 7'h6F;
            default: seg_v = 7'h00;
        endcase
        seg_v = blank ? 7'h00 : seg_v;
        return INVERT_SEG ? ~seg_v : seg_v;
    endfunction

    // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] t_v;
        t_v = sr;
        t_v[19:16] = (t_v[19:16] >= 4'd5) ? (t_v[19:16] + 4'd3) : t_v[19:16];
        t_v[15:12] = (t_v[15:12] >= 4'd5) ? (t_v[15:12] + 4'd3) : t_v[15:12];
        t_v[11:8]  = (t_v[11:8]  >= 4'd5) ? (t_v[11:8]  + 4'd3) : t_v[11:8];
        return {t_v[18:0], 1'b0};
    endfunction

    logic [1:0]  state_r;
    logic        valid_q_r;
    logic [19:0] shift_r;
    logic [2:0]  cnt_r;
    logic [7:0]  src_r;
    logic        pend_r;
    logic [7:0]  pend_data_r;

    logic        edge_s;
    logic [1:0]  state_nx_s;
    logic        load_s;
    logic [7:0]  load_data_s;
    logic        blank2_s;
    logic        blank1_s;

    assign edge_s = data_valid & ~valid_q_r;

    // Next-state and conversion-start selection; an edge in UPDATE wins over the pending slot.
    always_comb begin
        state_nx_s  = state_r;
        load_s      = 1'b0;
        load_data_s = data_in;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_CONV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (cnt_r == 3'd7) begin
                    state_nx_s = ST_UPDATE;
                end else begin
                    state_nx_s = ST_CONV;
                end
            end
            ST_UPDATE: begin
                if (edge_s) begin
                    load_s      = 1'b1;
                    load_data_s = data_in;
                    state_nx_s  = ST_CONV;
                end else if (pend_r) begin
                    load_s      = 1'b1;
                    load_data_s = pend_data_r;
                    state_nx_s  = ST_CONV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Leading-zero blanking uses the final BCD nibbles present during UPDATE.
    always_comb begin
        blank2_s = BLANK_LZ && (shift_r[19:16] == 4'd0);
        blank1_s = BLANK_LZ && (shift_r[19:16] == 4'd0) && (shift_r[15:12] == 4'd0);
    end

    // Control state, edge history, busy and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            valid_q_r <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            valid_q_r <= data_valid;
            busy      <= (state_nx_s != ST_IDLE);
            done      <= (state_r == ST_UPDATE);
        end
    end

    // Conversion datapath: shift register, iteration count and captured source byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= 20'd0;
            cnt_r   <= 3'd0;
            src_r   <= 8'd0;
        end else if (load_s) begin
            shift_r <= {12'd0, load_data_s};
            cnt_r   <= 3'd0;
            src_r   <= load_data_s;
        end else if (state_r == ST_CONV) begin
            shift_r <= dd_step(shift_r);
            cnt_r   <= cnt_r + 3'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // Depth-one pending slot: newest edge during CONV wins, drained or bypassed in UPDATE.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r      <= 1'b0;
            pend_data_r <= 8'd0;
        end else if ((state_r == ST_CONV) && edge_s) begin
            pend_r      <= 1'b1;
            pend_data_r <= data_in;
        end else if (state_r == ST_UPDATE) begin
            pend_r      <= 1'b0;
        end else begin
            pend_r      <= pend_r;
        end
    end

    // Display outputs change only at UPDATE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ledr <= 8'h00;
            hex0 <= seg_encode(4'd0, 1'b0);
            hex1 <= seg_encode(4'd0, BLANK_LZ);
            hex2 <= seg_encode(4'd0, BLANK_LZ);
        end else if (state_r == ST_UPDATE) begin
            ledr <= src_r;
            hex0 <= seg_encode(shift_r[11:8], 1'b0);
            hex1 <= seg_encode(shift_r[15:12], blank1_s);
            hex2 <= seg_encode(shift_r[19:16], blank2_s);
        end else begin
            ledr <= ledr;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed scenarios plus random traffic against
// a countdown/queue reference model with arithmetic decimal conversion.
module tb_result_display;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;

    logic [7:0] ledr_a, ledr_b, ledr_c;
    logic [6:0] hex0_a, hex1_a, hex2_a;
    logic [6:0] hex0_b, hex1_b, hex2_b;
    logic [6:0] hex0_c, hex1_c, hex2_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    result_display #(.INVERT_SEG(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .ledr(ledr_a), .hex0(hex0_a), .hex1(hex1_a), .hex2(hex2_a), .busy(busy_a), .done(done_a));
    result_display #(.INVERT_SEG(1'b1), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .ledr(ledr_b), .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b), .busy(busy_b), .done(done_b));
    result_display #(.INVERT_SEG(1'b0), .BLANK_LZ(1'b1)) dut_ah (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .ledr(ledr_c), .hex0(hex0_c), .hex1(hex1_c), .hex2(hex2_c), .busy(busy_c), .done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit m_vq, m_active, m_done;
    int m_rem, m_cur, m_disp;
    int m_pend[$];

    // Scenario observation counters
    int done_cnt, busy_run, busy_max;
    bit saw_100;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_hex(input int val, input int pos, input bit inv, input bit blz);
        logic [6:0] tbl [10];
        int h, t, o, dg;
        bit blank;
        logic [6:0] seg;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        dg = (pos == 2) ? h : ((pos == 1) ? t : o);
        blank = (pos == 2) ? (blz && h == 0) : ((pos == 1) ? (blz && h == 0 && t == 0) : 1'b0);
        seg = blank ? 7'h00 : tbl[dg];
        return inv ? ~seg : seg;
    endfunction

    task automatic m_start(input int v);
        m_cur = v;
        m_rem = 9;
        m_active = 1'b1;
        m_pend.delete();
    endtask

    task automatic model_step(input bit r, input bit v, input int d);
        bit e;
        if (r) begin
            m_vq = 1'b0; m_active = 1'b0; m_rem = 0; m_pend.delete();
            m_disp = 0; m_done = 1'b0;
        end else begin
            e = v && !m_vq;
            m_vq = v;
            m_done = 1'b0;
            if (m_active) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_disp = m_cur;
                    m_done = 1'b1;
                    if (e) m_start(d);
                    else if (m_pend.size() > 0) m_start(m_pend.pop_front());
                    else m_active = 1'b0;
                end else if (e) begin
                    m_pend.delete();
                    m_pend.push_back(d);
                end
            end else if (e) begin
                m_start(d);
            end
        end
    endtask

    task automatic compare_all();
        check("ledr", ledr_a, m_disp);
        check("ledr_nb", ledr_b, m_disp);
        check("busy", busy_a, int'(m_active));
        check("done", done_a, int'(m_done));
        check("hex0", hex0_a, exp_hex(m_disp, 0, 1'b1, 1'b1));
        check("hex1", hex1_a, exp_hex(m_disp, 1, 1'b1, 1'b1));
        check("hex2", hex2_a, exp_hex(m_disp, 2, 1'b1, 1'b1));
        check("hex0_nb", hex0_b, exp_hex(m_disp, 0, 1'b1, 1'b0));
        check("hex1_nb", hex1_b, exp_hex(m_disp, 1, 1'b1, 1'b0));
        check("hex2_nb", hex2_b, exp_hex(m_disp, 2, 1'b1, 1'b0));
        check("hex0_ah", hex0_c, exp_hex(m_disp, 0, 1'b0, 1'b1));
        check("hex1_ah", hex1_c, exp_hex(m_disp, 1, 1'b0, 1'b1));
        check("hex2_ah", hex2_c, exp_hex(m_disp, 2, 1'b0, 1'b1));
    endtask

    // Apply inputs before the edge, advance the model at the edge, compare on the falling edge.
    task automatic tick(input bit r, input bit v, input logic [7:0] d);
        reset = r;
        data_valid = v;
        data_in = d;
        @(posedge clk);
        model_step(r, v, int'(d));
        @(negedge clk);
        compare_all();
        done_cnt += int'(done_a);
        busy_run = busy_a ? busy_run + 1 : 0;
        if (busy_run > busy_max) busy_max = busy_run;
        if (ledr_a == 8'd100) saw_100 = 1'b1;
    endtask

    task automatic run(input int n, input bit v, input logic [7:0] d);
        for (int i = 0; i < n; i++) tick(1'b0, v, d);
    endtask

    task automatic clear_obs();
        done_cnt = 0; busy_run = 0; busy_max = 0; saw_100 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; data_valid = 1'b0; data_in = 8'd0;
        clear_obs();
        @(negedge clk);
        tick(1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b0, 8'd0);
        check("rst_hex0", hex0_a, 7'h40);
        check("rst_hex1", hex1_a, 7'h7F);
        check("rst_hex2", hex2_a, 7'h7F);
        check("rst_hex1_nb", hex1_b, 7'h40);

        // 255 -> "255"
        clear_obs();
        tick(1'b0, 1'b1, 8'hFF);
        run(11, 1'b1, 8'hFF);
        run(3, 1'b0, 8'h00);
        check("ff_done_cnt", done_cnt, 1);
        check("ff_ledr", ledr_a, 8'hFF);
        check("ff_hex2", hex2_a, 7'h24);
        check("ff_hex1", hex1_a, 7'h12);
        check("ff_hex0", hex0_a, 7'h12);
        check("ff_busy_len", busy_max, 9);

        // 7 -> blanked leading zeros vs. shown zeros
        clear_obs();
        tick(1'b0, 1'b1, 8'h07);
        run(12, 1'b0, 8'h00);
        check("d7_hex0", hex0_a, 7'h78);
        check("d7_hex1", hex1_a, 7'h7F);
        check("d7_hex2", hex2_a, 7'h7F);
        check("d7_hex1_nb", hex1_b, 7'h40);
        check("d7_hex2_nb", hex2_b, 7'h40);

        // Valid held high: single conversion
        clear_obs();
        run(30, 1'b1, 8'd128);
        run(3, 1'b0, 8'd0);
        check("hold_done_cnt", done_cnt, 1);
        check("hold_ledr", ledr_a, 8'd128);

        // Pending overwrite: 100 replaced by 42
        clear_obs();
        tick(1'b0, 1'b1, 8'd5);
        run(2, 1'b0, 8'd0);
        tick(1'b0, 1'b1, 8'd100);
        tick(1'b0, 1'b0, 8'd0);
        tick(1'b0, 1'b1, 8'd42);
        run(20, 1'b0, 8'd0);
        check("pend_done_cnt", done_cnt, 2);
        check("pend_busy_len", busy_max, 18);
        check("pend_no100", int'(saw_100), 0);
        check("pend_ledr", ledr_a, 8'd42);
        check("pend_hex1", hex1_a, 7'h19);
        check("pend_hex0", hex0_a, 7'h24);

        // Reset mid-conversion aborts, then 0 converts normally
        clear_obs();
        tick(1'b0, 1'b1, 8'd99);
        run(3, 1'b1, 8'd99);
        tick(1'b1, 1'b0, 8'd0);
        run(12, 1'b0, 8'd0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_ledr", ledr_a, 8'd0);
        check("abort_busy", busy_a, 0);
        tick(1'b0, 1'b1, 8'd0);
        run(11, 1'b0, 8'd0);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_hex0", hex0_a, 7'h40);

        // Edge landing on the UPDATE cycle
        clear_obs();
        tick(1'b0, 1'b1, 8'd10);
        run(8, 1'b0, 8'd0);
        tick(1'b0, 1'b1, 8'd200);
        check("upd_ledr10", ledr_a, 8'd10);
        run(9, 1'b0, 8'd0);
        check("upd_ledr200", ledr_a, 8'd200);
        run(3, 1'b0, 8'd0);
        check("upd_busy_len", busy_max, 18);
        check("upd_done_cnt", done_cnt, 2);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
        end
        run(12, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/result_display.md
# result_display

Downstream stage of the Ax²+Bx+C evaluator. It watches the evaluator's 8-bit result and result-valid outputs and captures the result on each rising edge of valid. It converts the value to three decimal digits using a sequential shift-and-add-3 (double-dabble) converter. It drives LEDR with the binary value and HEX2..HEX0 with the decimal digits, and holds at most one newer result pending while a conversion is in progress.

## Interface
- INVERT_SEG, 1: 1 = segment outputs active-low (board HEX displays); 0 = active-high.
- BLANK_LZ, 1: 1 = blank leading-zero digits on hex2/hex1; 0 = always show all three digits.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- data_in  in  8  unsigned result from evaluator.
- data_valid  in  1  evaluator result-valid level; only its 0→1 transition matters.
- ledr  out  8  binary value of last completed conversion.
- hex0  out  7  ones digit, seg[6:0] = g,f,e,d,c,b,a.
- hex1  out  7  tens digit.
- hex2  out  7  hundreds digit (0..2).
- busy  out  1  high while converting or updating.
- done  out  1  one-cycle pulse when displays update.

## Operation
- Edge detect: registered copy valid_q of data_valid. The edge is (data_valid & ~valid_q). valid_q resets to 0, so valid already high when reset is released counts as an edge on the first cycle.
- States: IDLE, CONV, UPDATE.
- IDLE: on edge, load shift reg with {12'b0, data_in}, cnt←0, go to CONV.
- CONV, one iteration per cycle:
  - In each BCD nibble (bits 19:16, 15:12, 11:8), add 3 to any nibble ≥5.
  - Shift the whole 20-bit reg left by 1.
  - cnt increments each cycle. After the iteration with cnt=7, go to UPDATE.
- UPDATE:
  - ledr←binary source value. The captured source byte is kept separately from the shift reg.
  - digit registers ← BCD nibbles; done←1.
  - Then: if an edge occurs this cycle, load data_in and go to CONV. Else if pending, load pend_data, clear pending, go to CONV. Else go to IDLE.
- Pending: an edge detected in CONV sets pend←1 and pend_data←data_in. A later edge overwrites pend_data (newest wins, depth 1). An edge in UPDATE bypasses the pending slot and clears pending.
- Segment encoding (active-high form; inverted when INVERT_SEG=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Blank = 00.
- Blanking (BLANK_LZ=1): hex2 blank if hundreds=0; hex1 blank if hundreds=0 and tens=0. hex0 is never blank.
- Reset values:
  - state IDLE; pend 0; ledr 8'h00; busy 0; done 0.
  - Digits 0, so hex0 shows "0". With BLANK_LZ=1, hex1 and hex2 are blank; with BLANK_LZ=0 they show "0".
  - Active-low values: hex0=7'h40, blank=7'h7F.
- Reset mid-conversion aborts the conversion, discards pending, and produces no done.

## Timing
- Edge sampled at posedge k → CONV iterations at edges k+1..k+8 → UPDATE at edge k+9.
- After edge k+9: new ledr/hex visible and done=1 for exactly one cycle.
- Latency is 9 cycles from the clock edge that first samples data_valid high.
- busy registered = (state≠IDLE): high after edge k through the cycle preceding edge k+9's transition to IDLE, i.e. 9 cycles.
- busy stays continuously high across back-to-back conversions.
- Back-to-back throughput: one result per 9 cycles. A pending result starts at the UPDATE edge, with no IDLE gap.
- Outputs change only at UPDATE; no intermediate digits are ever displayed.
- data_in needs to be stable only at the sampling edge.

## Test plan
- Reset, then data_in=8'hFF, valid 0→1 → 9 cycles later ledr=FF; hex2/hex1/hex0 = "2","5","5" (7'h24, 7'h12, 7'h12 active-low); single done pulse.
- data_in=8'h07 edge → hex0=7'h78, hex1=hex2=7'h7F (blank). Repeat with BLANK_LZ=0 → hex1=hex2=7'h40.
- data_valid held high 30 cycles with data_in=8'd128 → exactly one conversion, one done, display "128".
- Edge with 8'd5, then edges at +3 (8'd100) and +5 (8'd42) during CONV:
  - first update shows "5"; the second conversion starts with no gap and shows "42".
  - 100 is never displayed; exactly 2 done pulses; busy high 18 consecutive cycles.
- Edge with 8'd99, then reset asserted at cycle +4 for 1 cycle → all outputs return to reset values; no done; the next edge with 8'd0 displays "0" normally.
- Edge with 8'd10, then a second edge (8'd200) landing exactly on the UPDATE cycle → "10" displayed, then "200" 9 cycles later with busy never dropping.
